clock_ctrl: RTL and testbench

Time-keeping and time-setting controller for the digital clock. It divides the system clock into a one-second tick and sequences the seconds, minutes and hours counter chains through single-cycle increment strobes. It also runs a button-driven set-mode state machine that lets the user advance hours, minutes or seconds individually, and drives a blink enable for the field being edited. It sits between the debounced front-panel buttons and the `count60`-style counter chains.

---
 rtl/clock_ctrl.sv | 129 ++++++++++++
 tb/tb_clock_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_ctrl.sv
// clock_ctrl: one-second prescaler, carry strobes and button-driven
// set-mode sequencer with a blink enable for the edited field.
module clock_ctrl #(
    parameter int TICK_DIV = 100000000,
    parameter int CNT_W    = 27
) (
    input  logic       ck,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       sec_at59,
    input  logic       min_at59,
    output logic       up_sec,
    output logic       up_min,
    output logic       up_hr,
    output logic [1:0] mode,
    output logic       blink
);

    localparam logic [1:0] S_RUN = 2'b00;
    localparam logic [1:0] S_HR  = 2'b01;
    localparam logic [1:0] S_MIN = 2'b10;
    localparam logic [1:0] S_SEC = 2'b11;

    localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_MAX = CNT_W'(TICK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [1:0]       r_state;
    logic             r_prev_mode;
    logic             r_prev_inc;
    logic [CNT_W-1:0] r_presc;
    logic [CNT_W-1:0] r_bcnt;
    logic             r_blink;
    logic             r_up_sec;
    logic             r_up_min;
    logic             r_up_hr;

    logic             w_mode_edge;
    logic             w_inc_edge;
    logic             w_run;
    logic             w_tick;
    logic             w_inc_ok;
    logic [1:0]       w_nxt_state;

    // Edge detection, tick detection and next-state decode
    always_comb begin
        w_mode_edge = btn_mode & ~r_prev_mode;
        w_inc_edge  = btn_inc & ~r_prev_inc;
        w_run       = (r_state == S_RUN);
        w_tick      = w_run && (r_presc == TICK_MAX);
        // A mode change in the same cycle swallows the increment
        w_inc_ok    = w_inc_edge & ~w_mode_edge & ~w_run;
        w_nxt_state = w_mode_edge ? r_state + 2'd1 : r_state;
    end

    // Button history; held buttons across reset release give no edge
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_mode <= 1'b1;
            r_prev_inc  <= 1'b1;
        end else begin
            r_prev_mode <= btn_mode;
            r_prev_inc  <= btn_inc;
        end
    end

    // Mode state machine: RUN -> HR -> MIN -> SEC -> RUN
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // One-second prescaler, free-running only in RUN
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (!w_run || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + ONE;
        end
    end

    // Single-cycle increment strobes: auto carry in RUN, manual in set modes
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_up_sec <= 1'b0;
            r_up_min <= 1'b0;
            r_up_hr  <= 1'b0;
        end else begin
            r_up_sec <= w_tick
                      | (w_inc_ok & (r_state == S_SEC));
            r_up_min <= (w_tick & sec_at59)
                      | (w_inc_ok & (r_state == S_MIN));
            r_up_hr  <= (w_tick & sec_at59 & min_at59)
                      | (w_inc_ok & (r_state == S_HR));
        end
    end

    // Blink half-period timer, restarted on every entry into a set mode
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt  <= '0;
            r_blink <= 1'b0;
        end else if (w_nxt_state == S_RUN) begin
            r_bcnt  <= '0;
            r_blink <= 1'b0;
        end else if (w_mode_edge) begin
            r_bcnt  <= '0;
            r_blink <= 1'b1;
        end else if (r_bcnt == HALF_MAX) begin
            r_bcnt  <= '0;
            r_blink <= ~r_blink;
        end else begin
            r_bcnt  <= r_bcnt + ONE;
        end
    end

    assign up_sec = r_up_sec;
    assign up_min = r_up_min;
    assign up_hr  = r_up_hr;
    assign mode   = r_state;
    assign blink  = r_blink;

endmodule

// File: tb/tb_clock_ctrl.sv
// tb_clock_ctrl: directed stimulus with a strobe scoreboard; expected
// pulses are queued by edge number and popped by a negedge monitor.
module tb_clock_ctrl;

    logic       ck = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       sec_at59 = 1'b0;
    logic       min_at59 = 1'b0;
    logic       up_sec;
    logic       up_min;
    logic       up_hr;
    logic [1:0] mode;
    logic       blink;

    clock_ctrl #(.TICK_DIV(8), .CNT_W(4)) dut (
        .ck       (ck),
        .rst_n    (rst_n),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .sec_at59 (sec_at59),
        .min_at59 (min_at59),
        .up_sec   (up_sec),
        .up_min   (up_min),
        .up_hr    (up_hr),
        .mode     (mode),
        .blink    (blink)
    );

    always #5 ck = ~ck;

    typedef struct packed {
        int   c;
        logic s;
        logic m;
        logic h;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   B;
    int   B2;

    // Rising-edge counter; edge N is the N-th posedge since time 0
    always @(posedge ck) cyc <= cyc + 1;

    // Monitor: every strobe must match the oldest queued expectation
    always @(negedge ck) begin
        if (rst_n) begin
            while (q.size() > 0 && q[0].c < cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL missed_strobe: no pulse, required s/m/h=%b%b%b at edge %0d",
                         q[0].s, q[0].m, q[0].h, q[0].c);
                void'(q.pop_front());
            end
            if (up_sec | up_min | up_hr) begin
                n_chk++;
                if (q.size() == 0 || q[0].c != cyc) begin
                    n_fail++;
                    $display("FAIL unexpected_strobe: s/m/h=%b%b%b at edge %0d, required none",
                             up_sec, up_min, up_hr, cyc);
                end else begin
                    e = q.pop_front();
                    if ({up_sec, up_min, up_hr} != {e.s, e.m, e.h}) begin
                        n_fail++;
                        $display("FAIL strobe_value at edge %0d: got s/m/h=%b%b%b, required %b%b%b",
                                 cyc, up_sec, up_min, up_hr, e.s, e.m, e.h);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (edge %0d)", nm, act, exp, cyc);
        end
    endtask

    // Advance to 1 time unit after edge k
    task automatic at(input int k);
        while (cyc < k) begin
            @(posedge ck);
            #1;
        end
    endtask

    task automatic push(input int c, input logic s, input logic m, input logic h);
        q.push_back({c, s, m, h});
    endtask

    task automatic press_mode(input int k);
        at(k);
        btn_mode = 1'b1;
        at(k + 1);
        btn_mode = 1'b0;
    endtask

    task automatic press_inc(input int k);
        at(k);
        btn_inc = 1'b1;
        at(k + 1);
        btn_inc = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit hit at edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("reset_mode", int'(mode), 0);
        chk("reset_blink", int'(blink), 0);
        chk("reset_strobes", int'({up_sec, up_min, up_hr}), 0);
        @(posedge ck);
        @(posedge ck);
        #4 rst_n = 1'b1;
        B = cyc;

        // Free-running ticks every 8 edges, no carries
        push(B + 8, 1, 0, 0);
        push(B + 16, 1, 0, 0);
        push(B + 24, 1, 0, 0);
        push(B + 32, 1, 0, 0);
        at(B + 36);

        // Full carry, then seconds-only carry
        sec_at59 = 1'b1;
        min_at59 = 1'b1;
        push(B + 40, 1, 1, 1);
        at(B + 44);
        min_at59 = 1'b0;
        push(B + 48, 1, 1, 0);
        at(B + 50);
        sec_at59 = 1'b0;

        // Mode cycling with blink timing
        press_mode(B + 50);
        at(B + 51);
        chk("mode_set_hr", int'(mode), 1);
        for (int i = 0; i < 8; i++) begin
            at(B + 51 + i);
            chk($sformatf("blink_hr_%0d", i), int'(blink), (i < 4) ? 1 : 0);
        end
        press_mode(B + 60);
        at(B + 61);
        chk("mode_set_min", int'(mode), 2);
        chk("blink_min_entry", int'(blink), 1);
        press_mode(B + 64);
        at(B + 65);
        chk("mode_set_sec", int'(mode), 3);
        chk("blink_sec_entry", int'(blink), 1);
        push(B + 77, 1, 0, 0);
        press_mode(B + 68);
        at(B + 69);
        chk("mode_run", int'(mode), 0);
        chk("blink_run", int'(blink), 0);

        // Manual minute set: no carry into hours
        press_mode(B + 78);
        press_mode(B + 80);
        at(B + 81);
        chk("mode_manual_min", int'(mode), 2);
        min_at59 = 1'b1;
        push(B + 83, 0, 1, 0);
        press_inc(B + 82);
        push(B + 85, 0, 1, 0);
        press_inc(B + 84);
        push(B + 87, 0, 1, 0);
        press_inc(B + 86);
        min_at59 = 1'b0;

        // Simultaneous mode and inc edges in SET_HR
        press_mode(B + 88);
        press_mode(B + 90);
        press_mode(B + 92);
        at(B + 93);
        chk("mode_back_hr", int'(mode), 1);
        at(B + 94);
        btn_mode = 1'b1;
        btn_inc = 1'b1;
        at(B + 95);
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        chk("simul_mode", int'(mode), 2);

        // Asynchronous reset while a manual up_sec is in flight
        press_mode(B + 96);
        at(B + 98);
        btn_inc = 1'b1;
        push(B + 99, 1, 0, 0);
        at(B + 99);
        chk("pre_reset_mode", int'(mode), 3);
        chk("pre_reset_up_sec", int'(up_sec), 1);
        #6 rst_n = 1'b0;
        #1;
        chk("async_up_sec", int'(up_sec), 0);
        chk("async_mode", int'(mode), 0);
        chk("async_blink", int'(blink), 0);
        @(posedge ck);
        @(posedge ck);
        #4 rst_n = 1'b1;
        B2 = cyc;
        push(B2 + 8, 1, 0, 0);
        at(B2 + 3);
        btn_inc = 1'b0;
        at(B2 + 12);
        chk("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
